// File: rtl/spike_pkg.sv
// Shared spike-bus definitions used by both the transmitter and the synapse column.
// The address width here must match the synapse address comparator.
package spike_pkg;

  localparam int SPIKE_ADDR_WIDTH = 8;

  typedef logic [SPIKE_ADDR_WIDTH-1:0] spikeAddrType;

endpackage : spike_pkg

// File: rtl/spike_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr, wrapping modulo N, and reports the first set request
// as a one-hot grant plus its encoded index.
module rr_arbiter
  import spike_pkg::*;
#(
  parameter int N         = 16,
  parameter int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid
);

  // Walk the N rotated positions starting at ptr; the first hit wins
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = IDX_WIDTH'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/spike_tx_arbiter.sv
// Spike bus transmitter: buffers one pending event per neuron source and
// serialises them as (valid, address) beats with round-robin fairness.
// bus_hold stalls emission while keeping buffered events.
// Optional build macro: SPIKE_TX_DROP_CNT_EN adds the saturating drop_count output.
module spike_tx_arbiter
  import spike_pkg::*;
#(
  parameter int N_SOURCES      = 16,
  parameter int ADDR_WIDTH     = SPIKE_ADDR_WIDTH,
  parameter int BASE_ADDR      = 0,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SOURCES-1:0]      spike_req,
  input  logic                      bus_hold,
  output logic                      spike_valid,
  output logic [ADDR_WIDTH-1:0]     spike_address,
  output logic [N_SOURCES-1:0]      pending
`ifdef SPIKE_TX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

  localparam int IDX_WIDTH = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  // Elaboration-time sanity checks on the parameter set
  if (N_SOURCES < 2 || N_SOURCES > 256) begin : g_bad_sources
    $error("spike_tx_arbiter: N_SOURCES must be in 2..256");
  end
  if ((longint'(BASE_ADDR) + longint'(N_SOURCES) - 1) >= (longint'(1) << ADDR_WIDTH)) begin : g_bad_width
    $error("spike_tx_arbiter: BASE_ADDR+N_SOURCES-1 does not fit in ADDR_WIDTH");
  end
  if (DROP_CNT_WIDTH < 1) begin : g_bad_drop_width
    $error("spike_tx_arbiter: DROP_CNT_WIDTH must be at least 1");
  end

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [N_SOURCES-1:0] cand;
  logic [N_SOURCES-1:0] arb_grant;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic                 arb_valid;
  logic                 do_grant;
  logic [N_SOURCES-1:0] grant_vec;
  logic [N_SOURCES-1:0] pending_next;
  logic [IDX_WIDTH-1:0] ptr_next;

  // A fresh pulse competes in its own cycle alongside buffered events
  assign cand = pending | spike_req;

  rr_arbiter #(
    .N         (N_SOURCES),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_arbiter (
    .req         (cand),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (grant_idx),
    .grant_valid (arb_valid)
  );

  assign do_grant  = arb_valid & ~bus_hold;
  assign grant_vec = arb_grant & {N_SOURCES{do_grant}};

  // Next pending flags: a granted source keeps only a new coincident pulse,
  // others accumulate; a pulse on an already-pending source is lost
  always_comb begin
    pending_next = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      if (grant_vec[i]) begin
        pending_next[i] = pending[i] & spike_req[i];
      end else begin
        pending_next[i] = pending[i] | spike_req[i];
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time
  always_comb begin
    ptr_next = '0;
    if (grant_idx != IDX_WIDTH'(N_SOURCES - 1)) begin
      ptr_next = grant_idx + 1'b1;
    end
  end

  // Pending flags, pointer and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= '0;
      rr_ptr        <= '0;
      spike_valid   <= 1'b0;
      spike_address <= '0;
    end else begin
      pending     <= pending_next;
      spike_valid <= do_grant;
      if (do_grant) begin
        spike_address <= BASE + ADDR_WIDTH'(grant_idx);
        rr_ptr        <= ptr_next;
      end
    end
  end

`ifdef SPIKE_TX_DROP_CNT_EN
  localparam int SUM_WIDTH = DROP_CNT_WIDTH + 9;
  localparam logic [SUM_WIDTH-1:0] DROP_MAX = {{9{1'b0}}, {DROP_CNT_WIDTH{1'b1}}};

  logic [N_SOURCES-1:0] drop_vec;
  logic [SUM_WIDTH-1:0] drop_inc;
  logic [SUM_WIDTH-1:0] drop_sum;

  assign drop_vec = spike_req & pending & ~grant_vec;

  // Count lost events this cycle and form the unsaturated running total
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      drop_inc = drop_inc + SUM_WIDTH'(drop_vec[i]);
    end
    drop_sum = SUM_WIDTH'(drop_count) + drop_inc;
  end

  // Saturating lost-event counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_sum > DROP_MAX) begin
      drop_count <= '1;
    end else begin
      drop_count <= drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end
`endif

endmodule : spike_tx_arbiter

// File: tb/tb_spike_tx_arbiter.sv
// Self-checking bench for spike_tx_arbiter (N_SOURCES=16, BASE_ADDR=0x20).
// Drop counter checks are active when SPIKE_TX_DROP_CNT_EN is defined.
module tb_spike_tx_arbiter;

  localparam int N  = 16;
  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  spike_req;
  logic          bus_hold;
  logic          spike_valid;
  logic [AW-1:0] spike_address;
  logic [N-1:0]  pending;
`ifdef SPIKE_TX_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [N-1:0]  req;
    logic          hold;
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
    logic [N-1:0]  exp_pending;
    int            exp_drop;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  spike_tx_arbiter #(
    .N_SOURCES      (N),
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (32'h20),
    .DROP_CNT_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .spike_req     (spike_req),
    .bus_hold      (bus_hold),
    .spike_valid   (spike_valid),
    .spike_address (spike_address),
    .pending       (pending)
`ifdef SPIKE_TX_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [N-1:0] req, input logic hold);
    spike_req = req;
    bus_hold  = hold;
  endtask

  task automatic checkOutput(input string name, input logic exp_valid,
                             input logic [AW-1:0] exp_addr,
                             input logic [N-1:0] exp_pending, input int exp_drop);
    checks++;
    if (spike_valid !== exp_valid) begin
      failures++;
      $display("[TB] FAIL %s spike_valid got=%0b expected=%0b", name, spike_valid, exp_valid);
    end
    checks++;
    if (spike_address !== exp_addr) begin
      failures++;
      $display("[TB] FAIL %s spike_address got=0x%02h expected=0x%02h", name, spike_address, exp_addr);
    end
    checks++;
    if (pending !== exp_pending) begin
      failures++;
      $display("[TB] FAIL %s pending got=0x%04h expected=0x%04h", name, pending, exp_pending);
    end
`ifdef SPIKE_TX_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'(exp_drop)) begin
      failures++;
      $display("[TB] FAIL %s drop_count got=%0d expected=%0d", name, drop_count, exp_drop);
    end
`else
    if (exp_drop < 0) $display("[TB] note: negative drop expectation in %s", name);
`endif
  endtask

  initial begin
    logic [N-1:0] exp_p;
    checks   = 0;
    failures = 0;

    // Single pulse, then hold-with-buffer, then drop under hold
    vecs[0]  = '{16'h0008, 1'b0, 1'b1, 8'h23, 16'h0000, 0};
    vecs[1]  = '{16'h0000, 1'b0, 1'b0, 8'h23, 16'h0000, 0};
    vecs[2]  = '{16'h0020, 1'b1, 1'b0, 8'h23, 16'h0020, 0};
    vecs[3]  = '{16'h0000, 1'b1, 1'b0, 8'h23, 16'h0020, 0};
    vecs[4]  = '{16'h0000, 1'b1, 1'b0, 8'h23, 16'h0020, 0};
    vecs[5]  = '{16'h0000, 1'b1, 1'b0, 8'h23, 16'h0020, 0};
    vecs[6]  = '{16'h0000, 1'b1, 1'b0, 8'h23, 16'h0020, 0};
    vecs[7]  = '{16'h0000, 1'b0, 1'b1, 8'h25, 16'h0000, 0};
    vecs[8]  = '{16'h0000, 1'b0, 1'b0, 8'h25, 16'h0000, 0};
    vecs[9]  = '{16'h0004, 1'b1, 1'b0, 8'h25, 16'h0004, 0};
    vecs[10] = '{16'h0004, 1'b1, 1'b0, 8'h25, 16'h0004, 1};
    vecs[11] = '{16'h0000, 1'b0, 1'b1, 8'h22, 16'h0000, 1};
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 8'h22, 16'h0000, 1};
    // Two sources requesting every cycle: alternating grants, one drop per cycle once both pend
    vecs[13] = '{16'h0003, 1'b0, 1'b1, 8'h20, 16'h0002, 1};
    vecs[14] = '{16'h0003, 1'b0, 1'b1, 8'h21, 16'h0003, 1};
    vecs[15] = '{16'h0003, 1'b0, 1'b1, 8'h20, 16'h0003, 2};
    vecs[16] = '{16'h0003, 1'b0, 1'b1, 8'h21, 16'h0003, 3};
    vecs[17] = '{16'h0000, 1'b0, 1'b1, 8'h20, 16'h0002, 3};
    vecs[18] = '{16'h0000, 1'b0, 1'b1, 8'h21, 16'h0000, 3};
    vecs[19] = '{16'h0000, 1'b0, 1'b0, 8'h21, 16'h0000, 3};
    // Two simultaneous drops under hold count as two
    vecs[20] = '{16'h0300, 1'b1, 1'b0, 8'h21, 16'h0300, 3};
    vecs[21] = '{16'h0300, 1'b1, 1'b0, 8'h21, 16'h0300, 5};
    vecs[22] = '{16'h0000, 1'b0, 1'b1, 8'h28, 16'h0200, 5};
    vecs[23] = '{16'h0000, 1'b0, 1'b1, 8'h29, 16'h0000, 5};
    vecs[24] = '{16'h0000, 1'b0, 1'b0, 8'h29, 16'h0000, 5};

    reset = 1'b1;
    applyStimulus('0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 1'b0, 8'h00, 16'h0000, 0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].req, vecs[i].hold);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_addr,
                  vecs[i].exp_pending, vecs[i].exp_drop);
    end

    // Asynchronous reset between cycles restores the idle state and pointer 0
    applyStimulus('0, 1'b0);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset_idle", 1'b0, 8'h00, 16'h0000, 0);
    @(negedge clk);
    reset = 1'b0;

    // All sources at once: 0x20..0x2F back to back, then idle
    applyStimulus(16'hFFFF, 1'b0);
    @(negedge clk);
    applyStimulus('0, 1'b0);
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      exp_p = 16'hFFFF;
      exp_p = exp_p << (k + 1);
      checkOutput($sformatf("burst_beat%0d", k), 1'b1, 8'(8'h20 + k), exp_p, 0);
    end
    @(negedge clk);
    checkOutput("burst_end", 1'b0, 8'h2F, 16'h0000, 0);

    // Reset asserted mid-burst, away from any clock edge
    applyStimulus(16'hFFFF, 1'b0);
    @(negedge clk);
    applyStimulus('0, 1'b0);
    @(negedge clk);
    checkOutput("midburst_beat1", 1'b1, 8'h21, 16'hFFFC, 0);
    #2 reset = 1'b1;
    #1 checkOutput("midburst_reset", 1'b0, 8'h00, 16'h0000, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(16'h0080, 1'b0);
    @(negedge clk);
    checkOutput("after_reset_src7", 1'b1, 8'h27, 16'h0000, 0);
    applyStimulus('0, 1'b0);
    @(negedge clk);
    checkOutput("after_reset_idle", 1'b0, 8'h27, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spike_tx_arbiter
